// File: rtl/crc_stream.sv
// Streaming CRC engine: valid/ready word input with first/last framing, BITS_PER_CYCLE bits per clock.
// Optional CRC_STREAM_REFLECT_EN adds a per-packet reflect input (LSB-first bytes, reversed result).
module crc_stream #(
  parameter int                   DATA_WIDTH     = 32,
  parameter int                   CRC_WIDTH      = 16,
  parameter logic [CRC_WIDTH-1:0] POLYNOMIAL     = 16'h1021,
  parameter logic [CRC_WIDTH-1:0] INIT_VALUE     = 16'hFFFF,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT        = 16'h0000,
  parameter int                   BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] data_in,
`ifdef CRC_STREAM_REFLECT_EN
  input  logic                  reflect,
`endif
  output logic                  busy,
  output logic [CRC_WIDTH-1:0]  result,
  output logic                  result_valid
);

  localparam int N     = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CRC_WIDTH-1:0]  crc_q, crc_d, crc_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  last_q, last_d;
  logic                  refl_q, refl_d;
  logic [CRC_WIDTH-1:0]  res_q, res_d;
  logic                  refl_in;
  logic                  accept;

`ifdef CRC_STREAM_REFLECT_EN
  assign refl_in = reflect;
`else
  assign refl_in = 1'b0;
`endif

  // Unrolled direct-form update, MSB of the chunk first.
  function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] c,
                                                    input logic [BITS_PER_CYCLE-1:0] b);
    logic [CRC_WIDTH-1:0] r;
    r = c;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--)
      r = {r[CRC_WIDTH-2:0], 1'b0} ^ ((r[CRC_WIDTH-1] ^ b[i]) ? POLYNOMIAL : '0);
    return r;
  endfunction

  // Reversing bits within each byte lets the MSB-first shifter consume bytes LSB first.
  function automatic logic [DATA_WIDTH-1:0] byte_rev(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = d;
    for (int i = 0; i < DATA_WIDTH; i++)
      r[(i / 8) * 8 + 7 - (i % 8)] = d[i];
    return r;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] finalize(input logic [CRC_WIDTH-1:0] c,
                                                    input logic refl);
    logic [CRC_WIDTH-1:0] r;
    r = c;
    if (refl)
      for (int i = 0; i < CRC_WIDTH; i++) r[i] = c[CRC_WIDTH-1-i];
    return r ^ XOR_OUT;
  endfunction

  assign in_ready     = (state_q != SHIFT) && !clear;
  assign accept       = in_valid && in_ready;
  assign busy         = (state_q == SHIFT);
  assign result_valid = (state_q == DONE);
  assign result       = result_valid ? res_q : '0;
  assign crc_nxt      = crc_step(crc_q, word_q[DATA_WIDTH-1 -: BITS_PER_CYCLE]);

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    last_d  = last_q;
    refl_d  = refl_q;
    res_d   = res_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      crc_d  = crc_nxt;
      word_d = word_q << BITS_PER_CYCLE;
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = last_q ? DONE : WAIT;
        if (last_q) res_d = finalize(crc_nxt, refl_q);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (accept) begin
      // Only an open packet (WAIT) continues its CRC unless the word is flagged first.
      state_d = SHIFT;
      word_d  = refl_in ? byte_rev(data_in) : data_in;
      last_d  = in_last;
      refl_d  = refl_in;
      if (state_q != WAIT || in_first) crc_d = INIT_VALUE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      crc_q   <= INIT_VALUE;
      cnt_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      refl_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      last_q  <= last_d;
      refl_q  <= refl_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: doc/crc_stream.md
Name: crc_stream

Overview:
- Parametrised successor to the team's single-word serial CRC engine.
- Computes a configurable CRC (width, polynomial, init, final XOR) over a packet of one or more DATA_WIDTH-bit words, processing BITS_PER_CYCLE bits per clock.
- Input uses a valid/ready handshake with first/last framing; the result is held with a valid flag until the next packet starts.
- Sits behind the Avalon-MM slave wrapper as the CRC accelerator in the system.

Parameters:
- DATA_WIDTH, 32, input word width in bits; must be a multiple of BITS_PER_CYCLE.
- CRC_WIDTH, 16, CRC register width; range 3..32.
- POLYNOMIAL, 16'h1021, generator polynomial without the implicit x^CRC_WIDTH term.
- INIT_VALUE, 16'hFFFF, CRC register value loaded at packet start.
- XOR_OUT, 16'h0000, value XORed into the CRC register to form the result.
- BITS_PER_CYCLE, 1, bits consumed per clock; allowed values 1, 2, 4, 8.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous abort: returns to IDLE and drops result_valid.
- in_valid, input, 1, data_in/in_first/in_last are valid.
- in_ready, output, 1, block can accept a word this cycle.
- in_first, input, 1, this word begins a new packet; the CRC register is loaded with INIT_VALUE before the word is processed.
- in_last, input, 1, this word ends the packet.
- data_in, input, DATA_WIDTH, word to process, MSB first.
- busy, output, 1, a word is being shifted (state SHIFT).
- result, output, CRC_WIDTH, final CRC; forced to 0 while result_valid = 0.
- result_valid, output, 1, result holds the CRC of the last completed packet.

Behaviour:
- Reset (reset_n low, asynchronous): state = IDLE; crc_reg = INIT_VALUE; bit counter = 0; in_ready = 1; busy = 0; result_valid = 0; result = 0.
- States and transitions:
  - IDLE -> SHIFT on accept (in_valid & in_ready). The word is always treated as first, so in_first is ignored here.
  - SHIFT:
    - in_ready = 0, busy = 1.
    - Processes BITS_PER_CYCLE bits per cycle, MSB of the latched word first.
    - Lasts N = DATA_WIDTH / BITS_PER_CYCLE cycles.
    - On the final cycle, goes to DONE if the latched last flag = 1, else to WAIT.
  - WAIT: packet is open, in_ready = 1. On accept -> SHIFT. If in_first = 1, crc_reg is reloaded with INIT_VALUE before shifting.
  - DONE: result_valid = 1, in_ready = 1. On accept -> SHIFT as a new packet (INIT load); result_valid drops on the same edge.
- Per-bit update (direct, non-augmented form): fb = crc_reg[CRC_WIDTH-1] ^ d; crc_reg = {crc_reg[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLYNOMIAL : 0). With BITS_PER_CYCLE > 1, this update is unrolled combinationally within one cycle.
- Accept edge: the data word, in_last, and the INIT decision are latched. No CRC bits are processed on the accept edge itself.
- Latency: an accept on edge T gives result_valid high after edge T+N (for example, N = 32 when DATA_WIDTH = 32 and BITS_PER_CYCLE = 1).
- Throughput: one word per N+1 cycles.
- result = crc_reg ^ XOR_OUT, registered on entry to DONE, then held stable until the next accept, clear, or reset.
- clear has priority over an accept in the same cycle. In_valid asserted during clear is not accepted; in_ready is low that cycle.
- reset_n asserted mid-SHIFT aborts immediately: no partial result, result_valid = 0.
- in_valid during SHIFT is ignored (in_ready = 0); the source must hold the word until in_ready is high.
- in_first and in_last both set on one word: single-word packet.
- Bit counter wraps to 0 on leaving SHIFT and never exceeds N-1.

Optional Feature:
- Macro: CRC_STREAM_REFLECT_EN.
- When defined:
  - Adds input port reflect (1 bit), sampled on each accept.
  - When reflect = 1, each byte of data_in is processed LSB first; bytes are still taken in order from most significant to least significant.
  - The final CRC register is bit-reversed before XOR_OUT is applied.
- When undefined: no reflect port; behaviour is exactly as described in Behaviour (MSB first, no output reversal).

Test Plan:
- CRC_WIDTH = 8, POLYNOMIAL = 8'h07, INIT_VALUE = 0, XOR_OUT = 0, DATA_WIDTH = 8. Single word 8'h01 with first = last = 1 -> result = 8'h07, result_valid high exactly 8 cycles after the accept.
- Default parameters, DATA_WIDTH = 8. ASCII "123456789" sent as 9 words (first on '1', last on '9') with random in_valid gaps -> result = 16'h29B1. in_ready is never high during SHIFT.
- Same CRC as the previous scenario, DATA_WIDTH = 8, BITS_PER_CYCLE = 8, same stimulus -> result = 16'h29B1. Each word completes 1 cycle after its accept.
- CRC_STREAM_REFLECT_EN defined, CRC_WIDTH = 32, POLYNOMIAL = 32'h04C11DB7, INIT_VALUE = XOR_OUT = 32'hFFFFFFFF, reflect = 1. "123456789" sent as 9 bytes -> result = 32'hCBF43926.
- Abort handling:
  - clear pulsed mid-SHIFT of a 4-word packet -> IDLE, result_valid = 0.
  - Restarting with the CRC-8 single-byte case -> result = 8'h07.
  - reset_n pulsed mid-SHIFT -> all outputs return to their reset values asynchronously.
- Back-to-back packets: accept a new first word in DONE -> result_valid drops on the accept edge. Then send a word in WAIT with in_first = 1 -> CRC restarts from INIT, and the result matches a fresh single-word computation.
